// File: rtl/cp0_ctrl_pkg.sv
// Shared CPU constants: CP0 register addresses, exception codes, vectors,
// and the exception request bundle used by the CP0 controller.
package cp0_ctrl_pkg;

   // CP0 register numbers
   localparam logic [4:0] CP0_INDEX    = 5'd0;
   localparam logic [4:0] CP0_RANDOM   = 5'd1;
   localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
   localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
   localparam logic [4:0] CP0_WIRED    = 5'd6;
   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_ENTRYHI  = 5'd10;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   // Cause.ExcCode values
   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_MOD  = 5'd1,
      EXC_TLBL = 5'd2,
      EXC_TLBS = 5'd3,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_SYS  = 5'd8
   } exc_code_e;

   // Exception vectors
   localparam logic [31:0] VEC_REFILL  = 32'h8000_0000;
   localparam logic [31:0] VEC_GENERAL = 32'h8000_0180;

   // Software-writable Status bits: IM[15:8], UM[4], EXL[1], IE[0]
   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF13;

   // Qualified exception requests, one bit per source
   typedef struct packed {
      logic intr;
      logic addr_err;
      logic tlb_mod;
      logic tlb_refill;
      logic tlb_invalid;
      logic syscall;
   } exc_req_t;

endpackage

// File: rtl/cp0_ctrl_timer.sv
// Count/Compare timer: divided Count, Compare register and sticky timer pending.
import cp0_ctrl_pkg::*;

module cp0_timer #(
   parameter int COUNT_DIV = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        count_wen,
   input  logic        compare_wen,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        timer_pending
);

   localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

   logic [DIV_W-1:0] div_cnt;
   logic             tick;

   assign tick = (div_cnt == DIV_W'(COUNT_DIV - 1));

   // Count advances once per COUNT_DIV cycles; a software load restarts the divider
   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         div_cnt <= '0;
      end else if (count_wen) begin
         count   <= wdata;
         div_cnt <= '0;
      end else if (tick) begin
         count   <= count + 32'd1;
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Pending sets when an increment lands on Compare; only a Compare write clears it
   always_ff @(posedge clk) begin
      if (reset) begin
         compare       <= 32'hFFFF_FFFF;
         timer_pending <= 1'b0;
      end else if (compare_wen) begin
         compare       <= wdata;
         timer_pending <= 1'b0;
      end else if (!count_wen && tick && ((count + 32'd1) == compare)) begin
         timer_pending <= 1'b1;
      end
   end

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 system control: TLB support registers, Status/Cause/EPC, exception
// prioritisation and redirect, ERET, and the Count/Compare timer.
import cp0_ctrl_pkg::*;

module cp0_ctrl #(
   parameter int TLB_ENTRIES = 16,
   parameter int NUM_HW_INT  = 6,
   parameter int COUNT_DIV   = 2,
   localparam int IDX_W      = $clog2(TLB_ENTRIES)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_pause_i,
   input  logic                  cp0_wen_i,
   input  logic [4:0]            cp0_addr_i,
   input  logic [31:0]           cp0_data_i,
   output logic [31:0]           cp0_data_o,
   input  logic                  exc_syscall_i,
   input  logic                  exc_addr_error_i,
   input  logic                  exc_tlb_refill_i,
   input  logic                  exc_tlb_invalid_i,
   input  logic                  exc_tlb_mod_i,
   input  logic                  exc_rw_i,
   input  logic [31:0]           exc_badvaddr_i,
   input  logic [31:0]           exc_pc_i,
   input  logic                  eret_i,
   input  logic [NUM_HW_INT-1:0] hw_int_i,
   input  logic                  tlbp_valid_i,
   input  logic                  tlbp_miss_i,
   input  logic [IDX_W-1:0]      tlbp_index_i,
   output logic                  exc_taken_o,
   output logic [31:0]           exc_vector_o,
   output logic [31:0]           epc_o,
   output logic [31:0]           status_o,
   output logic [31:0]           cause_o,
   output logic [31:0]           entryhi_o,
   output logic [31:0]           entrylo0_o,
   output logic [31:0]           entrylo1_o,
   output logic [IDX_W-1:0]      index_o,
   output logic [IDX_W-1:0]      random_o,
   output logic                  timer_int_o
);

   localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);

   // Architectural state
   logic [7:0]            im_q;
   logic                  um_q, exl_q, ie_q;
   logic [1:0]            ip_sw_q;
   logic [NUM_HW_INT-1:0] ip_hw_q;
   exc_code_e             exccode_q;
   logic [31:0]           epc_q, badvaddr_q, wired_q;
   logic [18:0]           vpn2_q;
   logic [7:0]            asid_q;
   logic [25:0]           lo0_q, lo1_q;
   logic                  idx_p_q;
   logic [IDX_W-1:0]      idx_q, random_q;

   logic [31:0] count, compare;
   logic        timer_pending;

   logic [7:0]  ip;
   logic        int_req, exc_taken, wr_en;
   exc_req_t    req;
   exc_code_e   exc_code;
   logic        set_bad, is_tlb, refill_sel;

   // Cause.IP view; IP7 is shared between the top hardware line and the timer
   always_comb begin
      ip                   = '0;
      ip[1:0]              = ip_sw_q;
      ip[2 +: NUM_HW_INT]  = ip_hw_q;
      ip[7]                = ip[7] | timer_pending;
   end

   assign int_req = (|(ip & im_q)) & ie_q & ~exl_q;

   // Per-source qualification of exception requests
   always_comb begin
      req             = '0;
      req.intr        = int_req;
      req.addr_err    = exc_addr_error_i;
      req.tlb_mod     = exc_tlb_mod_i & exc_rw_i;
      req.tlb_refill  = exc_tlb_refill_i;
      req.tlb_invalid = exc_tlb_invalid_i;
      req.syscall     = exc_syscall_i;
   end

   // Priority encode the winning exception and its side effects
   always_comb begin
      exc_code   = EXC_SYS;
      set_bad    = 1'b0;
      is_tlb     = 1'b0;
      refill_sel = 1'b0;
      if (req.intr) begin
         exc_code = EXC_INT;
      end else if (req.addr_err) begin
         exc_code = exc_rw_i ? EXC_ADES : EXC_ADEL;
         set_bad  = 1'b1;
      end else if (req.tlb_mod) begin
         exc_code = EXC_MOD;
         set_bad  = 1'b1;
         is_tlb   = 1'b1;
      end else if (req.tlb_refill || req.tlb_invalid) begin
         exc_code   = exc_rw_i ? EXC_TLBS : EXC_TLBL;
         set_bad    = 1'b1;
         is_tlb     = 1'b1;
         refill_sel = req.tlb_refill;
      end
   end

   assign exc_taken    = (|req) & ~cpu_pause_i & ~reset;
   assign exc_taken_o  = exc_taken;
   assign exc_vector_o = (refill_sel && !exl_q) ? VEC_REFILL : VEC_GENERAL;

   // An exception in the same cycle swallows the MTC0
   assign wr_en = cp0_wen_i & ~cpu_pause_i & ~exc_taken;

   cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
      .clk           (clk),
      .reset         (reset),
      .count_wen     (wr_en && (cp0_addr_i == CP0_COUNT)),
      .compare_wen   (wr_en && (cp0_addr_i == CP0_COMPARE)),
      .wdata         (cp0_data_i),
      .count         (count),
      .compare       (compare),
      .timer_pending (timer_pending)
   );

   // Random free-runs (even when paused) between TLB_ENTRIES-1 and Wired
   always_ff @(posedge clk) begin
      if (reset)
         random_q <= RAND_TOP;
      else if (wr_en && (cp0_addr_i == CP0_WIRED))
         random_q <= RAND_TOP;
      else if (wired_q >= 32'(TLB_ENTRIES))
         random_q <= RAND_TOP;
      else if (32'(random_q) == wired_q)
         random_q <= RAND_TOP;
      else
         random_q <= random_q - 1'b1;
   end

   // Exception entry, ERET, TLBP results and MTC0 writes
   always_ff @(posedge clk) begin
      if (reset) begin
         im_q       <= '0;
         um_q       <= 1'b0;
         exl_q      <= 1'b1;
         ie_q       <= 1'b0;
         ip_sw_q    <= '0;
         ip_hw_q    <= '0;
         exccode_q  <= EXC_INT;
         epc_q      <= '0;
         badvaddr_q <= '0;
         wired_q    <= '0;
         vpn2_q     <= '0;
         asid_q     <= '0;
         lo0_q      <= '0;
         lo1_q      <= '0;
         idx_p_q    <= 1'b0;
         idx_q      <= '0;
      end else begin
         ip_hw_q <= hw_int_i;
         if (!cpu_pause_i) begin
            if (exc_taken) begin
               exl_q     <= 1'b1;
               exccode_q <= exc_code;
               if (!exl_q)  epc_q      <= exc_pc_i;
               if (set_bad) badvaddr_q <= exc_badvaddr_i;
               if (is_tlb)  vpn2_q     <= exc_badvaddr_i[31:13];
            end else begin
               if (wr_en) begin
                  case (cp0_addr_i)
                     CP0_INDEX:    if (!tlbp_valid_i) idx_q <= cp0_data_i[IDX_W-1:0];
                     CP0_ENTRYLO0: lo0_q   <= cp0_data_i[25:0];
                     CP0_ENTRYLO1: lo1_q   <= cp0_data_i[25:0];
                     CP0_WIRED:    wired_q <= cp0_data_i;
                     CP0_ENTRYHI: begin
                        vpn2_q <= cp0_data_i[31:13];
                        asid_q <= cp0_data_i[7:0];
                     end
                     CP0_STATUS: begin
                        im_q  <= cp0_data_i[15:8];
                        um_q  <= cp0_data_i[4];
                        exl_q <= cp0_data_i[1];
                        ie_q  <= cp0_data_i[0];
                     end
                     CP0_CAUSE:    ip_sw_q <= cp0_data_i[9:8];
                     CP0_EPC:      epc_q   <= cp0_data_i;
                     default: ;
                  endcase
               end
               if (eret_i) exl_q <= 1'b0;
            end
            if (tlbp_valid_i) begin
               idx_p_q <= tlbp_miss_i;
               if (!tlbp_miss_i) idx_q <= tlbp_index_i;
            end
         end
      end
   end

   assign status_o    = {16'h0, im_q, 3'b000, um_q, 2'b00, exl_q, ie_q};
   assign cause_o     = {16'h0, ip, 1'b0, exccode_q, 2'b00};
   assign entryhi_o   = {vpn2_q, 5'b0, asid_q};
   assign entrylo0_o  = {6'b0, lo0_q};
   assign entrylo1_o  = {6'b0, lo1_q};
   assign epc_o       = epc_q;
   assign index_o     = idx_q;
   assign random_o    = random_q;
   assign timer_int_o = timer_pending;

   // MFC0 read mux; a same-cycle MTC0 is not visible until the next cycle
   always_comb begin
      cp0_data_o = '0;
      case (cp0_addr_i)
         CP0_INDEX:    cp0_data_o = {idx_p_q, {(31-IDX_W){1'b0}}, idx_q};
         CP0_RANDOM:   cp0_data_o = 32'(random_q);
         CP0_ENTRYLO0: cp0_data_o = entrylo0_o;
         CP0_ENTRYLO1: cp0_data_o = entrylo1_o;
         CP0_WIRED:    cp0_data_o = wired_q;
         CP0_BADVADDR: cp0_data_o = badvaddr_q;
         CP0_COUNT:    cp0_data_o = count;
         CP0_ENTRYHI:  cp0_data_o = entryhi_o;
         CP0_COMPARE:  cp0_data_o = compare;
         CP0_STATUS:   cp0_data_o = status_o;
         CP0_CAUSE:    cp0_data_o = cause_o;
         CP0_EPC:      cp0_data_o = epc_q;
         default:      cp0_data_o = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl with a register-file level reference model.
module tb_cp0_ctrl;

   localparam int N   = 16;
   localparam int DIV = 2;
   localparam int NHW = 6;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_pause_i, cp0_wen_i;
   logic [4:0]  cp0_addr_i;
   logic [31:0] cp0_data_i, cp0_data_o;
   logic        exc_syscall_i, exc_addr_error_i, exc_tlb_refill_i, exc_tlb_invalid_i, exc_tlb_mod_i, exc_rw_i;
   logic [31:0] exc_badvaddr_i, exc_pc_i;
   logic        eret_i;
   logic [NHW-1:0] hw_int_i;
   logic        tlbp_valid_i, tlbp_miss_i;
   logic [3:0]  tlbp_index_i;
   logic        exc_taken_o;
   logic [31:0] exc_vector_o, epc_o, status_o, cause_o, entryhi_o, entrylo0_o, entrylo1_o;
   logic [3:0]  index_o, random_o;
   logic        timer_int_o;

   int checks = 0;
   int errors = 0;

   cp0_ctrl #(.TLB_ENTRIES(N), .NUM_HW_INT(NHW), .COUNT_DIV(DIV)) dut (
      .clk(clk), .reset(reset), .cpu_pause_i(cpu_pause_i),
      .cp0_wen_i(cp0_wen_i), .cp0_addr_i(cp0_addr_i), .cp0_data_i(cp0_data_i), .cp0_data_o(cp0_data_o),
      .exc_syscall_i(exc_syscall_i), .exc_addr_error_i(exc_addr_error_i),
      .exc_tlb_refill_i(exc_tlb_refill_i), .exc_tlb_invalid_i(exc_tlb_invalid_i), .exc_tlb_mod_i(exc_tlb_mod_i),
      .exc_rw_i(exc_rw_i), .exc_badvaddr_i(exc_badvaddr_i), .exc_pc_i(exc_pc_i),
      .eret_i(eret_i), .hw_int_i(hw_int_i),
      .tlbp_valid_i(tlbp_valid_i), .tlbp_miss_i(tlbp_miss_i), .tlbp_index_i(tlbp_index_i),
      .exc_taken_o(exc_taken_o), .exc_vector_o(exc_vector_o), .epc_o(epc_o), .status_o(status_o),
      .cause_o(cause_o), .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o), .entrylo1_o(entrylo1_o),
      .index_o(index_o), .random_o(random_o), .timer_int_o(timer_int_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // ---------------- reference model: CP0 as an addressed register file ----------------
   logic [31:0] m_reg [0:31];
   int unsigned m_rnd;
   logic [31:0] m_cnt_base;
   longint      m_cnt_t0, cyc = 0;
   logic        m_pend;
   logic [NHW-1:0] m_hw;
   bit          m_ok = 0;

   function automatic logic [31:0] wmask(input int a);
      case (a)
         0:       return 32'(N - 1);
         2, 3:    return 32'h03FF_FFFF;
         6, 14:   return 32'hFFFF_FFFF;
         10:      return 32'hFFFF_E0FF;
         12:      return 32'h0000_FF13;
         13:      return 32'h0000_0300;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] m_count();
      return m_cnt_base + 32'((cyc - m_cnt_t0) / DIV);
   endfunction

   function automatic logic [7:0] m_ip();
      logic [7:0] ip;
      ip = {6'b0, m_reg[13][9:8]} | ({2'b0, m_hw} << 2);
      if (m_pend) ip[7] = 1'b1;
      return ip;
   endfunction

   function automatic logic [31:0] m_read(input int a);
      case (a)
         1:       return 32'(m_rnd);
         9:       return m_count();
         13:      return {16'h0, m_ip(), m_reg[13][7:0]};
         0, 2, 3, 6, 8, 10, 11, 12, 14: return m_reg[a];
         default: return 32'h0;
      endcase
   endfunction

   // Returns the winning ExcCode, or -1 when nothing is requested
   function automatic int m_code(output bit refill);
      refill = 0;
      if ((m_ip() & m_reg[12][15:8]) != 0 && m_reg[12][0] && !m_reg[12][1]) return 0;
      if (exc_addr_error_i) return exc_rw_i ? 5 : 4;
      if (exc_tlb_mod_i && exc_rw_i) return 1;
      if (exc_tlb_refill_i || exc_tlb_invalid_i) begin
         refill = exc_tlb_refill_i;
         return exc_rw_i ? 3 : 2;
      end
      if (exc_syscall_i) return 8;
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
      m_reg[12]  = 32'h2;
      m_reg[11]  = 32'hFFFF_FFFF;
      m_rnd      = N - 1;
      m_cnt_base = 0;
      m_cnt_t0   = cyc;
      m_pend     = 0;
      m_hw       = '0;
      m_ok       = 1;
   endtask

   task automatic model_step();
      int code, a;
      bit rf, tk, wr;
      logic [31:0] oc, wd;
      if (reset) begin
         model_reset();
         return;
      end
      code = m_code(rf);
      tk   = (code >= 0) && !cpu_pause_i;
      wr   = cp0_wen_i && !cpu_pause_i && !tk;
      a    = int'(cp0_addr_i);
      wd   = cp0_data_i;
      oc   = m_count();
      if (wr && a == 6)                         m_rnd = N - 1;
      else if (m_reg[6] >= N || m_rnd == m_reg[6]) m_rnd = N - 1;
      else                                      m_rnd = m_rnd - 1;
      cyc++;
      if (wr && a == 9) begin
         m_cnt_base = wd;
         m_cnt_t0   = cyc;
      end
      if (wr && a == 11) begin
         m_reg[11] = wd;
         m_pend    = 0;
      end else if (!(wr && a == 9) && m_count() != oc && m_count() == m_reg[11]) begin
         m_pend = 1;
      end
      m_hw = hw_int_i;
      if (!cpu_pause_i) begin
         if (tk) begin
            if (!m_reg[12][1]) m_reg[14] = exc_pc_i;
            m_reg[12][1]   = 1'b1;
            m_reg[13][6:2] = code[4:0];
            if (code != 0 && code != 8) m_reg[8] = exc_badvaddr_i;
            if (code >= 1 && code <= 3) m_reg[10][31:13] = exc_badvaddr_i[31:13];
         end else begin
            if (wr && !(a == 0 && tlbp_valid_i))
               m_reg[a] = (m_reg[a] & ~wmask(a)) | (wd & wmask(a));
            if (eret_i) m_reg[12][1] = 1'b0;
         end
         if (tlbp_valid_i) begin
            m_reg[0][31] = tlbp_miss_i;
            if (!tlbp_miss_i) m_reg[0][3:0] = tlbp_index_i;
         end
      end
   endtask

   task automatic compare_step();
      int code;
      bit rf, tk;
      if (!m_ok) return;
      code = m_code(rf);
      tk   = (code >= 0) && !cpu_pause_i && !reset;
      chk("exc_taken", 32'(exc_taken_o), 32'(tk));
      if (tk) chk("exc_vector", exc_vector_o, (rf && !m_reg[12][1]) ? 32'h8000_0000 : 32'h8000_0180);
      chk("random",   32'(random_o), 32'(m_rnd));
      chk("index",    32'(index_o),  32'(m_reg[0][3:0]));
      chk("status",   status_o,   m_reg[12]);
      chk("cause",    cause_o,    m_read(13));
      chk("epc",      epc_o,      m_reg[14]);
      chk("entryhi",  entryhi_o,  m_reg[10]);
      chk("entrylo0", entrylo0_o, m_reg[2]);
      chk("entrylo1", entrylo1_o, m_reg[3]);
      chk("timer",    32'(timer_int_o), 32'(m_pend));
      chk("mfc0",     cp0_data_o, m_read(int'(cp0_addr_i)));
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      compare_step();
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      cpu_pause_i = 0; cp0_wen_i = 0; cp0_addr_i = 5'd0; cp0_data_i = 0;
      exc_syscall_i = 0; exc_addr_error_i = 0; exc_tlb_refill_i = 0; exc_tlb_invalid_i = 0;
      exc_tlb_mod_i = 0; exc_rw_i = 0; exc_badvaddr_i = 0; exc_pc_i = 0; eret_i = 0;
      hw_int_i = '0; tlbp_valid_i = 0; tlbp_miss_i = 0; tlbp_index_i = '0;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      cp0_wen_i = 1; cp0_addr_i = a; cp0_data_i = d;
      tick();
      cp0_wen_i = 0;
   endtask

   task automatic clr_exc();
      exc_syscall_i = 0; exc_addr_error_i = 0; exc_tlb_refill_i = 0;
      exc_tlb_invalid_i = 0; exc_tlb_mod_i = 0; exc_rw_i = 0; eret_i = 0;
   endtask

   initial begin
      idle();
      reset = 1;
      repeat (3) tick();
      cp0_addr_i = 5'd11; #1;
      chk("rst_compare", cp0_data_o, 32'hFFFF_FFFF);
      chk("rst_random", 32'(random_o), 32'd15);
      chk("rst_status", status_o, 32'h0000_0002);
      chk("rst_taken", 32'(exc_taken_o), 32'd0);
      reset = 0;

      // Wired=4: Random sweeps 15..4 then wraps
      mtc0(5'd6, 32'd4);
      chk("wired_rand0", 32'(random_o), 32'd15);
      for (int i = 1; i <= 12; i++) begin
         tick();
         chk("wired_seq", 32'(random_o), (i <= 11) ? 32'(15 - i) : 32'd15);
      end
      // Wired beyond the TLB: Random pinned
      mtc0(5'd6, 32'd20);
      repeat (3) tick();
      chk("wired_big", 32'(random_o), 32'd15);
      mtc0(5'd6, 32'd0);

      // Hardware interrupt
      hw_int_i = 6'b000001; exc_pc_i = 32'h1000_0040;
      tick();
      mtc0(5'd12, 32'h0000_0401);
      #1;
      chk("int_taken", 32'(exc_taken_o), 32'd1);
      chk("int_vector", exc_vector_o, 32'h8000_0180);
      tick();
      hw_int_i = '0;
      chk("int_code", cause_o & 32'h7C, 32'h0);
      chk("int_epc", epc_o, 32'h1000_0040);
      chk("int_status", status_o, 32'h0000_0403);

      // TLB refill on load with EXL=0, then again with EXL=1
      mtc0(5'd12, 32'h0);
      exc_tlb_refill_i = 1; exc_badvaddr_i = 32'h0040_3ABC; exc_pc_i = 32'h0040_0100; #1;
      chk("refill_vec0", exc_vector_o, 32'h8000_0000);
      tick();
      clr_exc(); cp0_addr_i = 5'd8; #1;
      chk("refill_code", cause_o & 32'h7C, 32'h08);
      chk("refill_bad", cp0_data_o, 32'h0040_3ABC);
      chk("refill_vpn2", 32'(entryhi_o[31:13]), 32'h201);
      chk("refill_epc", epc_o, 32'h0040_0100);
      exc_tlb_refill_i = 1; exc_pc_i = 32'h0040_0200; #1;
      chk("refill_vec1", exc_vector_o, 32'h8000_0180);
      tick();
      clr_exc();
      chk("refill_epc_keep", epc_o, 32'h0040_0100);

      // Priority: addr error (store) beats TLB mod and syscall
      exc_addr_error_i = 1; exc_tlb_mod_i = 1; exc_syscall_i = 1; exc_rw_i = 1; exc_badvaddr_i = 32'h0000_0003;
      tick(); clr_exc();
      chk("prio_ades", cause_o & 32'h7C, 32'h14);
      // TLB mod on a load is not a request; syscall wins
      exc_tlb_mod_i = 1; exc_syscall_i = 1;
      tick(); clr_exc();
      chk("prio_sys", cause_o & 32'h7C, 32'h20);
      // TLB mod store beats refill
      exc_tlb_mod_i = 1; exc_tlb_refill_i = 1; exc_rw_i = 1; exc_badvaddr_i = 32'hABCD_E000;
      tick(); clr_exc();
      chk("prio_mod", cause_o & 32'h7C, 32'h04);

      // ERET, then syscall+ERET together, then the same while paused
      eret_i = 1;
      tick(); clr_exc();
      chk("eret_exl", status_o, 32'h0);
      exc_syscall_i = 1; eret_i = 1; exc_pc_i = 32'h0040_0300;
      tick(); clr_exc();
      chk("syseret_status", status_o, 32'h2);
      chk("syseret_code", cause_o & 32'h7C, 32'h20);
      cpu_pause_i = 1; exc_syscall_i = 1; eret_i = 1; exc_pc_i = 32'h0040_0400; #1;
      chk("pause_taken", 32'(exc_taken_o), 32'd0);
      repeat (2) tick();
      cpu_pause_i = 0; clr_exc();
      chk("pause_status", status_o, 32'h2);
      chk("pause_epc", epc_o, 32'h0040_0300);

      // Exception discards a same-cycle MTC0
      exc_syscall_i = 1;
      mtc0(5'd14, 32'hDEAD_0000);
      clr_exc();
      chk("exc_vs_mtc0", epc_o, 32'h0040_0300);

      // MTC0/MFC0 same address: old value on read
      cp0_wen_i = 1; cp0_addr_i = 5'd14; cp0_data_i = 32'h1234_5678; #1;
      chk("rd_old", cp0_data_o, 32'h0040_0300);
      tick(); cp0_wen_i = 0;
      chk("rd_new", epc_o, 32'h1234_5678);

      // TLBP hit overrides MTC0 Index; miss sets P only
      tlbp_valid_i = 1; tlbp_index_i = 4'd9;
      mtc0(5'd0, 32'd3);
      chk("tlbp_hit", 32'(index_o), 32'd9);
      tlbp_miss_i = 1; tlbp_index_i = 4'd5;
      tick();
      tlbp_valid_i = 0; tlbp_miss_i = 0; cp0_addr_i = 5'd0; #1;
      chk("tlbp_miss", cp0_data_o, 32'h8000_0009);

      // Write masks and software interrupt
      mtc0(5'd2, 32'hFFFF_FFFF);
      chk("lo0_mask", entrylo0_o, 32'h03FF_FFFF);
      mtc0(5'd10, 32'hFFFF_FFFF);
      chk("ehi_mask", entryhi_o, 32'hFFFF_E0FF);
      mtc0(5'd13, 32'h0000_0300);
      mtc0(5'd12, 32'h0000_0101);
      #1;
      chk("swint_taken", 32'(exc_taken_o), 32'd1);
      tick();
      mtc0(5'd13, 32'h0);
      mtc0(5'd12, 32'hFFFF_FFFF);
      chk("status_mask", status_o, 32'h0000_FF13);
      mtc0(5'd12, 32'h2);

      // Timer: Compare=10, Count=0, divide-by-2 -> pending after 20 cycles
      mtc0(5'd11, 32'd10);
      mtc0(5'd9, 32'd0);
      repeat (19) tick();
      chk("timer_19", 32'(timer_int_o), 32'd0);
      tick();
      cp0_addr_i = 5'd9; #1;
      chk("timer_20", 32'(timer_int_o), 32'd1);
      chk("count_20", cp0_data_o, 32'd10);
      mtc0(5'd11, 32'hFFFF_FFFF);
      chk("timer_clr", 32'(timer_int_o), 32'd0);

      // Reset mid-operation beats pause, exceptions and writes
      cpu_pause_i = 1; exc_syscall_i = 1; cp0_wen_i = 1; cp0_addr_i = 5'd14; cp0_data_i = 32'h5555_5555;
      reset = 1; #1;
      chk("rst_mid_taken", 32'(exc_taken_o), 32'd0);
      tick();
      reset = 0; idle();
      chk("rst_mid_status", status_o, 32'h2);
      chk("rst_mid_epc", epc_o, 32'h0);
      chk("rst_mid_index", 32'(index_o), 32'd0);
      chk("rst_mid_random", 32'(random_o), 32'd15);
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 Parameter TLB_ENTRIES, 16, number of TLB entries (power of 2, 4..64); IDX_W = log2(TLB_ENTRIES).
REQ-002 Parameter NUM_HW_INT, 6, hardware interrupt lines (1..6).
REQ-003 Parameter COUNT_DIV, 2, clk cycles per Count increment (1..8).
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 cpu_pause_i  in  1  pipeline stall; freezes architectural updates except Random/Count/timer pending.
REQ-007 cp0_wen_i, cp0_addr_i, cp0_data_i  in  1/5/32  MTC0 write port.
REQ-008 cp0_data_o  out  32  MFC0 read data, combinational from cp0_addr_i.
REQ-009 exc_syscall_i, exc_addr_error_i, exc_tlb_refill_i, exc_tlb_invalid_i, exc_tlb_mod_i  in  1 each  exception requests.
REQ-010 exc_rw_i  in  1  1 = store access; exc_badvaddr_i  in  32  faulting address; exc_pc_i  in  32  PC of faulting instruction.
REQ-011 eret_i  in  1  ERET retiring; hw_int_i  in  NUM_HW_INT  level interrupts.
REQ-012 tlbp_valid_i  in  1, tlbp_miss_i  in  1, tlbp_index_i  in  IDX_W  TLBP result.
REQ-013 exc_taken_o  out  1, exc_vector_o  out  32  combinational redirect.
REQ-014 epc_o, status_o, cause_o, entryhi_o, entrylo0_o, entrylo1_o  out  32 each; index_o, random_o  out  IDX_W; timer_int_o  out  1.

Function
REQ-015 Address map: Index 0, Random 1, EntryLo0 2, EntryLo1 3, Wired 6, BadVAddr 8, Count 9, EntryHi 10, Compare 11, Status 12, Cause 13, EPC 14; other addresses read 0, writes ignored.
REQ-016 Field layout: Status IM[15:8], UM[4], EXL[1], IE[0]; Cause IP[15:8], ExcCode[6:2]; EntryHi VPN2[31:13], ASID[7:0]; EntryLo[25:0]; Index P[31], index[IDX_W-1:0]; unimplemented bits read 0.
REQ-017 Cause.IP[1:0] software-writable; IP[2+k] = hw_int_i[k] sampled each cycle; IP[7] = timer pending; unused IP bits read 0.
REQ-018 Random decrements every clk, including during pause; at value == Wired it wraps to TLB_ENTRIES-1; MTC0 to Wired also sets Random to TLB_ENTRIES-1.
REQ-019 Wired >= TLB_ENTRIES: Random holds TLB_ENTRIES-1.
REQ-020 Count increments by 1 every COUNT_DIV cycles, wraps 0xFFFFFFFF->0; MTC0 Count loads value and restarts divider.
REQ-021 When Count becomes equal to Compare, timer pending sets and stays set until MTC0 Compare clears it; timer_int_o = timer pending.
REQ-022 int_req = |(Cause.IP & Status.IM) & IE & ~EXL.
REQ-023 Priority, highest first: interrupt, addr error (ExcCode 4 load/5 store), TLB mod (1, stores only), TLB refill/invalid (2 load/3 store), syscall (8); interrupt ExcCode 0.
REQ-024 exc_taken_o = any qualified request & ~cpu_pause_i; same cycle, no latency.
REQ-025 On taken: EXL<=1; EPC<=exc_pc_i only if EXL was 0; ExcCode updated; BadVAddr<=exc_badvaddr_i for addr/TLB; EntryHi.VPN2<=exc_badvaddr_i[31:13] for TLB.
REQ-026 exc_vector_o = 0x8000_0000 for TLB refill with EXL=0; else 0x8000_0180.
REQ-027 eret_i & ~pause clears EXL; exception and ERET in same cycle: exception wins.
REQ-028 Exception and MTC0 in same cycle: MTC0 discarded.
REQ-029 tlbp_valid_i: Index.P<=tlbp_miss_i; index<=tlbp_index_i on hit; MTC0 Index same cycle ignored.
REQ-030 MTC0 and MFC0 same address same cycle: read returns old value.

Reset
REQ-031 On reset: Status=0x0000_0000 except EXL=1, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0xFFFF_FFFF, timer pending=0, Wired=0, Random=TLB_ENTRIES-1, Index=0, EntryHi/Lo0/Lo1=0, exc_taken_o=0.
REQ-032 Reset mid-operation overrides pause, exceptions and writes in that cycle.

Structure
REQ-033 CP0 addresses, ExcCode values and vector addresses belong in the shared CPU constants package.
REQ-034 Count/Compare/divider/timer pending form one sub-module, cp0_timer.

Verification
REQ-035 Reset, TLB_ENTRIES=16 -> Random=15, EXL=1, Compare=0xFFFFFFFF; MTC0 Wired=4 -> Random 15,14..4,15.
REQ-036 IE=1, EXL=0, IM[2]=1, hw_int_i[0]=1 -> exc_taken_o=1, ExcCode=0, EPC=exc_pc_i, vector 0x80000180, EXL=1 next cycle.
REQ-037 EXL=0, refill load at 0x00403ABC -> ExcCode=2, BadVAddr=0x00403ABC, VPN2=0x00201, vector 0x80000000; repeat with EXL=1 -> vector 0x80000180, EPC unchanged.
REQ-038 Compare=10, Count=0, COUNT_DIV=2 -> timer_int_o high at cycle 20; MTC0 Compare clears it.
REQ-039 syscall+eret same cycle -> EXL stays 1, ExcCode=8; same with cpu_pause_i=1 -> no state change, Random still decrements.
